// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: default widths
// and the fetch FSM state encoding.
package instr_fetch_ctrl_pkg;

  localparam int DEFAULT_ADDR_W  = 8;
  localparam int DEFAULT_INSTR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_STOP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_target_adder.sv
// Branch target computation: base + 1 + imm, wrapping modulo 2^ADDR_W.
// Purely combinational; there is no overflow indication.
module fetch_target_adder #(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] imm,
  output logic [ADDR_W-1:0] target
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  assign target = base + ONE + imm;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues req/ack reads to
// instruction memory, holds the fetched word for decode (valid/ready) and
// applies taken-branch redirects from execute. A word whose request was
// overtaken by a redirect is dropped via the discard flag.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter int                INSTR_W  = DEFAULT_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir_data,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               ir_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_base,
  input  logic [ADDR_W-1:0]  redirect_imm,
  input  logic               halt
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_t        state;
  fetch_state_t        state_nxt;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   pc_nxt;
  logic                discard;
  logic                discard_nxt;
  logic                ir_load;
  logic [ADDR_W-1:0]   target;

  fetch_target_adder #(
    .ADDR_W (ADDR_W)
  ) u_target_adder (
    .base   (redirect_base),
    .imm    (redirect_imm),
    .target (target)
  );

  // Handshake strobes are decoded straight from the state; the address is the PC.
  assign imem_req  = (state == ST_REQ);
  assign ir_valid  = (state == ST_HOLD);
  assign imem_addr = pc;

  // Next-state, next-PC, discard and IR-load decode; redirect wins in every state.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    discard_nxt = discard;
    ir_load     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (redirect) begin
          pc_nxt    = target;
          state_nxt = ST_REQ;
        end else if (halt) begin
          state_nxt = ST_STOP;
        end else begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect) begin
          // A simultaneous ack retires the stale request here; otherwise it is
          // still in flight and must be dropped when it returns.
          pc_nxt      = target;
          discard_nxt = ~imem_ack;
        end else if (imem_ack) begin
          if (discard) begin
            discard_nxt = 1'b0;
          end else begin
            ir_load   = 1'b1;
            pc_nxt    = pc + PC_ONE;
            state_nxt = ST_HOLD;
          end
        end else begin
          state_nxt = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_nxt    = target;
          state_nxt = ST_REQ;
        end else if (ir_ready) begin
          state_nxt = halt ? ST_STOP : ST_REQ;
        end else begin
          state_nxt = ST_HOLD;
        end
      end
      ST_STOP: begin
        if (redirect) begin
          pc_nxt    = target;
          state_nxt = ST_REQ;
        end else if (!halt) begin
          state_nxt = ST_REQ;
        end else begin
          state_nxt = ST_STOP;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, PC and discard flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      pc      <= RESET_PC;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      discard <= discard_nxt;
    end
  end

  // Instruction register: captures the word and its address on a kept ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_data <= {INSTR_W{1'b0}};
      ir_pc   <= {ADDR_W{1'b0}};
    end else if (ir_load) begin
      ir_data <= imem_data;
      ir_pc   <= pc;
    end else begin
      ir_data <= ir_data;
      ir_pc   <= ir_pc;
    end
  end

endmodule
